// File: rtl/fetch_stage_if.sv
// Instruction-memory read bus between the fetch stage and instruction memory.
interface fetch_stage_if #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned INSTR_WIDTH = 32
);
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_ready;
    logic [INSTR_WIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, one-outstanding memory reads
// and branch redirect with wrong-path squash.
module fetch_stage #(
    parameter int unsigned          PC_WIDTH    = 32,
    parameter int unsigned          INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic [1:0]             branch_select,
    input  logic                   flag_zero,
    input  logic                   flag_neg,
    input  logic [PC_WIDTH-1:0]    branch_target,
    fetch_stage_if.master          imem,
    output logic [INSTR_WIDTH-1:0] if_id_instr,
    output logic [PC_WIDTH-1:0]    if_id_pc,
    output logic                   if_id_valid,
    output logic [3:0]             opcode
);

    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t                 state;
    logic [PC_WIDTH-1:0]    pc;
    logic [PC_WIDTH-1:0]    hold_pc;
    logic [INSTR_WIDTH-1:0] hold_instr;
    logic                   taken;
    logic                   accept;

    // Branch resolution from select code and ALU flags.
    assign taken = (branch_select == 2'b01)
                 | ((branch_select == 2'b10) & flag_zero)
                 | ((branch_select == 2'b11) & flag_neg);

    // IF/ID can take a new entry unless it holds a valid one under stall.
    assign accept = !stall || !if_id_valid;

    // Opcode straight from the IF/ID register; a bubble reads as NOP.
    assign opcode = if_id_instr[INSTR_WIDTH-1 -: 4];

    // Fetch FSM, PC, hold buffer and IF/ID register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            hold_pc        <= '0;
            hold_instr     <= '0;
            imem.imem_req  <= 1'b0;
            imem.imem_addr <= '0;
            if_id_instr    <= '0;
            if_id_pc       <= '0;
            if_id_valid    <= 1'b0;
        end else begin
            // Request is a single-cycle pulse; only entry into REQ raises it.
            imem.imem_req <= 1'b0;

            // Default IF/ID behaviour: hold under stall, otherwise bubble.
            if (!(stall && if_id_valid)) begin
                if_id_instr <= '0;
                if_id_valid <= 1'b0;
            end

            if (taken) begin
                pc          <= branch_target;
                if_id_instr <= '0;
                if_id_valid <= 1'b0;
                hold_pc     <= '0;
                hold_instr  <= '0;
                // A read still in flight must be drained before refetching.
                if (state == REQ || (state == WAIT && !imem.imem_ready)) begin
                    state <= DRAIN;
                end else begin
                    state          <= REQ;
                    imem.imem_req  <= 1'b1;
                    imem.imem_addr <= branch_target;
                end
            end else begin
                case (state)
                    IDLE: begin
                        state          <= REQ;
                        imem.imem_req  <= 1'b1;
                        imem.imem_addr <= pc;
                    end
                    REQ: begin
                        state <= WAIT;
                    end
                    WAIT: begin
                        if (imem.imem_ready) begin
                            if (accept) begin
                                if_id_instr    <= imem.imem_rdata;
                                if_id_pc       <= pc;
                                if_id_valid    <= 1'b1;
                                pc             <= pc + PC_STEP;
                                state          <= REQ;
                                imem.imem_req  <= 1'b1;
                                imem.imem_addr <= pc + PC_STEP;
                            end else begin
                                hold_instr <= imem.imem_rdata;
                                hold_pc    <= pc;
                                state      <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (accept) begin
                            if_id_instr    <= hold_instr;
                            if_id_pc       <= hold_pc;
                            if_id_valid    <= 1'b1;
                            pc             <= pc + PC_STEP;
                            state          <= REQ;
                            imem.imem_req  <= 1'b1;
                            imem.imem_addr <= pc + PC_STEP;
                        end
                    end
                    DRAIN: begin
                        if (imem.imem_ready) begin
                            state          <= REQ;
                            imem.imem_req  <= 1'b1;
                            imem.imem_addr <= pc;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: two instances (RESET_PC 0 and
// 0xFFFFFFF8), each with a behavioural instruction memory.
module tb_fetch_stage;

    localparam int unsigned PW = 32;
    localparam int unsigned IW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0;
    logic          stall1 = 1'b0;
    logic [1:0]    bsel = 2'b00;
    logic          fz = 1'b0;
    logic          fn = 1'b0;
    logic [PW-1:0] btgt = '0;

    logic [IW-1:0] instr0, instr1;
    logic [PW-1:0] pc0, pc1;
    logic          valid0, valid1;
    logic [3:0]    op0, op1;

    int checks = 0;
    int errors = 0;

    logic [27:0] salt = '0;

    int unsigned lat0_min = 0;
    int unsigned lat0_max = 0;
    logic        pend0 = 1'b0;
    int unsigned cnt0 = 0;
    logic [31:0] paddr0 = '0;
    logic        pend1 = 1'b0;
    logic [31:0] paddr1 = '0;

    always #5 clk = ~clk;

    fetch_stage_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) m0 ();
    fetch_stage_if #(.PC_WIDTH(PW), .INSTR_WIDTH(IW)) m1 ();

    fetch_stage #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .rst(rst), .stall(stall), .branch_select(bsel),
        .flag_zero(fz), .flag_neg(fn), .branch_target(btgt), .imem(m0),
        .if_id_instr(instr0), .if_id_pc(pc0), .if_id_valid(valid0), .opcode(op0)
    );

    fetch_stage #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .RESET_PC(32'hFFFF_FFF8)) dut1 (
        .clk(clk), .rst(rst), .stall(stall1), .branch_select(2'b00),
        .flag_zero(1'b0), .flag_neg(1'b0), .branch_target(32'h0), .imem(m1),
        .if_id_instr(instr1), .if_id_pc(pc1), .if_id_valid(valid1), .opcode(op1)
    );

    // Memory contents: opcode nibble derived from address, body salted.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        word_of = {4'(a[5:2] + 4'd8), a[27:0] ^ salt};
    endfunction

    // Memory for dut0: random latency, one response per request.
    initial forever begin
        @(posedge clk);
        #1;
        if (rst) begin
            m0.imem_ready = 1'b0;
            m0.imem_rdata = '0;
            pend0 = 1'b0;
        end else begin
            m0.imem_ready = 1'b0;
            if (pend0) begin
                if (cnt0 == 0) begin
                    m0.imem_ready = 1'b1;
                    m0.imem_rdata = word_of(paddr0);
                    pend0 = 1'b0;
                end else begin
                    cnt0 = cnt0 - 1;
                end
            end
            if (m0.imem_req) begin
                checks++;
                if (pend0 || m0.imem_ready) begin
                    errors++;
                    $display("FAIL outstanding0: new req addr %h while %h unanswered", m0.imem_addr, paddr0);
                end
                pend0 = 1'b1;
                paddr0 = m0.imem_addr;
                cnt0 = $urandom_range(lat0_max, lat0_min);
            end
        end
    end

    // Memory for dut1: fixed minimum latency.
    initial forever begin
        @(posedge clk);
        #1;
        if (rst) begin
            m1.imem_ready = 1'b0;
            m1.imem_rdata = '0;
            pend1 = 1'b0;
        end else begin
            m1.imem_ready = 1'b0;
            if (pend1) begin
                m1.imem_ready = 1'b1;
                m1.imem_rdata = word_of(paddr1);
                pend1 = 1'b0;
            end
            if (m1.imem_req) begin
                checks++;
                if (m1.imem_ready) begin
                    errors++;
                    $display("FAIL outstanding1: new req addr %h while %h unanswered", m1.imem_addr, paddr1);
                end
                pend1 = 1'b1;
                paddr1 = m1.imem_addr;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        stall = 1'b0;
        stall1 = 1'b0;
        bsel = 2'b00;
        fz = 1'b0;
        fn = 1'b0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        checks++;
        if ({m0.imem_req, m0.imem_addr} !== 33'h0) begin
            errors++; $display("FAIL reset_imem0: got req %b addr %h, want 0/0", m0.imem_req, m0.imem_addr);
        end
        checks++;
        if ({instr0, pc0, valid0, op0} !== 69'h0) begin
            errors++; $display("FAIL reset_ifid0: got instr %h pc %h valid %b op %h, want all 0", instr0, pc0, valid0, op0);
        end
        checks++;
        if ({m1.imem_req, m1.imem_addr, instr1, pc1, valid1} !== 98'h0) begin
            errors++; $display("FAIL reset_dut1: got req %b addr %h instr %h pc %h valid %b, want all 0", m1.imem_req, m1.imem_addr, instr1, pc1, valid1);
        end
    endtask

    task automatic test_sequential;
        lat0_min = 0; lat0_max = 0;
        do_reset;
        tick;
        checks++;
        if (m0.imem_req !== 1'b1 || m0.imem_addr !== 32'h0) begin
            errors++; $display("FAIL seq_req0: got req %b addr %h, want 1/00000000", m0.imem_req, m0.imem_addr);
        end
        tick;
        checks++;
        if (m0.imem_req !== 1'b0 || valid0 !== 1'b0) begin
            errors++; $display("FAIL seq_wait: got req %b valid %b, want 0/0", m0.imem_req, valid0);
        end
        tick;
        checks++;
        if (valid0 !== 1'b1 || pc0 !== 32'h0 || op0 !== 4'b1000 || instr0 !== word_of(32'h0)) begin
            errors++; $display("FAIL seq_first: got valid %b pc %h op %b instr %h, want 1/0/1000/%h", valid0, pc0, op0, instr0, word_of(32'h0));
        end
        checks++;
        if (m0.imem_req !== 1'b1 || m0.imem_addr !== 32'h4) begin
            errors++; $display("FAIL seq_req1: got req %b addr %h, want 1/00000004", m0.imem_req, m0.imem_addr);
        end
        tick;
        checks++;
        if (valid0 !== 1'b0 || op0 !== 4'b0000) begin
            errors++; $display("FAIL seq_bubble: got valid %b op %b, want 0/0000", valid0, op0);
        end
        tick;
        checks++;
        if (valid0 !== 1'b1 || pc0 !== 32'h4 || op0 !== 4'b1001 || m0.imem_addr !== 32'h8 || m0.imem_req !== 1'b1) begin
            errors++; $display("FAIL seq_second: got valid %b pc %h op %b req %b addr %h, want 1/4/1001/1/8", valid0, pc0, op0, m0.imem_req, m0.imem_addr);
        end
    endtask

    // Continues from test_sequential: IF/ID holds pc 4, word for pc 8 in flight.
    task automatic test_stall_hold;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if (valid0 !== 1'b1 || pc0 !== 32'h4 || instr0 !== word_of(32'h4) || m0.imem_req !== 1'b0) begin
                errors++; $display("FAIL stall_hold%0d: got valid %b pc %h req %b, want 1/4/0", i, valid0, pc0, m0.imem_req);
            end
        end
        stall = 1'b0;
        tick;
        checks++;
        if (valid0 !== 1'b1 || pc0 !== 32'h8 || instr0 !== word_of(32'h8)) begin
            errors++; $display("FAIL stall_release: got valid %b pc %h instr %h, want 1/8/%h", valid0, pc0, instr0, word_of(32'h8));
        end
        checks++;
        if (m0.imem_req !== 1'b1 || m0.imem_addr !== 32'hC) begin
            errors++; $display("FAIL stall_next_req: got req %b addr %h, want 1/0000000c", m0.imem_req, m0.imem_addr);
        end
    endtask

    task automatic test_branch_drain;
        lat0_min = 3; lat0_max = 3;
        do_reset;
        tick;
        tick;
        bsel = 2'b10; fz = 1'b1; btgt = 32'h40;
        tick;
        bsel = 2'b00; fz = 1'b0;
        checks++;
        if (valid0 !== 1'b0 || op0 !== 4'b0000 || m0.imem_req !== 1'b0) begin
            errors++; $display("FAIL drain_redirect: got valid %b op %b req %b, want 0/0000/0", valid0, op0, m0.imem_req);
        end
        for (int i = 0; i < 10 && m0.imem_req !== 1'b1; i++) begin
            tick;
            checks++;
            if (valid0 !== 1'b0) begin
                errors++; $display("FAIL drain_discard: got valid %b pc %h, want valid 0", valid0, pc0);
            end
        end
        checks++;
        if (m0.imem_req !== 1'b1 || m0.imem_addr !== 32'h40) begin
            errors++; $display("FAIL drain_req: got req %b addr %h, want 1/00000040", m0.imem_req, m0.imem_addr);
        end
        for (int i = 0; i < 10 && valid0 !== 1'b1; i++) tick;
        checks++;
        if (valid0 !== 1'b1 || pc0 !== 32'h40 || instr0 !== word_of(32'h40)) begin
            errors++; $display("FAIL drain_target: got valid %b pc %h instr %h, want 1/40/%h", valid0, pc0, instr0, word_of(32'h40));
        end
    endtask

    task automatic test_branch_conditions;
        logic          z, n, exp_taken;
        logic [1:0]    sel;
        logic [31:0]   tgt;
        lat0_min = 0; lat0_max = 0;
        for (int i = 0; i < 16; i++) begin
            sel = 2'(i % 4);
            if (i < 8) begin
                z = 1'(i / 4);
                n = ~z;
            end else begin
                z = 1'($urandom % 2);
                n = 1'($urandom % 2);
            end
            tgt = $urandom & 32'hFFFF_FFFC;
            case (sel)
                2'b01:   exp_taken = 1'b1;
                2'b10:   exp_taken = z;
                2'b11:   exp_taken = n;
                default: exp_taken = 1'b0;
            endcase
            do_reset;
            tick;
            tick;
            bsel = sel; fz = z; fn = n; btgt = tgt;
            tick;
            bsel = 2'b00; fz = 1'b0; fn = 1'b0;
            checks++;
            if (m0.imem_req !== 1'b1 || m0.imem_addr !== (exp_taken ? tgt : 32'h4)) begin
                errors++; $display("FAIL cond_sel%b_z%b_n%b: got req %b addr %h, want 1/%h", sel, z, n, m0.imem_req, m0.imem_addr, exp_taken ? tgt : 32'h4);
            end
            checks++;
            if (valid0 !== !exp_taken || (!exp_taken && pc0 !== 32'h0)) begin
                errors++; $display("FAIL cond_ifid_sel%b: got valid %b pc %h, want valid %b", sel, valid0, pc0, !exp_taken);
            end
        end
    endtask

    task automatic test_squash_stall;
        logic [31:0] tgt;
        tgt = ($urandom & 32'h0000_FFFC) | 32'h100;
        lat0_min = 0; lat0_max = 0;
        do_reset;
        tick;
        tick;
        tick;
        stall = 1'b1;
        tick;
        tick;
        checks++;
        if (valid0 !== 1'b1 || pc0 !== 32'h0) begin
            errors++; $display("FAIL squash_pre: got valid %b pc %h, want 1/0", valid0, pc0);
        end
        bsel = 2'b01; btgt = tgt;
        tick;
        bsel = 2'b00;
        checks++;
        if (valid0 !== 1'b0 || instr0 !== 32'h0 || m0.imem_req !== 1'b1 || m0.imem_addr !== tgt) begin
            errors++; $display("FAIL squash_stall: got valid %b instr %h req %b addr %h, want 0/0/1/%h", valid0, instr0, m0.imem_req, m0.imem_addr, tgt);
        end
        tick;
        tick;
        checks++;
        if (valid0 !== 1'b1 || pc0 !== tgt || instr0 !== word_of(tgt)) begin
            errors++; $display("FAIL squash_holddrop: got valid %b pc %h instr %h, want 1/%h/%h", valid0, pc0, instr0, tgt, word_of(tgt));
        end
        stall = 1'b0;
    endtask

    task automatic test_random;
        logic [31:0] exp_pc, exp_req, prev_pc, prev_instr;
        logic        prev_valid, prev_stall;
        int          deliveries;
        exp_pc = 0; exp_req = 0; prev_pc = 0; prev_instr = 0;
        prev_valid = 0; prev_stall = 0; deliveries = 0;
        lat0_min = 0; lat0_max = 3;
        do_reset;
        for (int i = 0; i < 400; i++) begin
            tick;
            if (prev_stall && prev_valid) begin
                checks++;
                if (valid0 !== 1'b1 || pc0 !== prev_pc || instr0 !== prev_instr) begin
                    errors++; $display("FAIL rand_hold@%0d: got valid %b pc %h, want 1/%h", i, valid0, pc0, prev_pc);
                end
            end else if (valid0 === 1'b1) begin
                checks++;
                if (pc0 !== exp_pc || instr0 !== word_of(exp_pc)) begin
                    errors++; $display("FAIL rand_deliver@%0d: got pc %h instr %h, want %h/%h", i, pc0, instr0, exp_pc, word_of(exp_pc));
                end
                exp_pc = exp_pc + 4;
                deliveries++;
            end
            checks++;
            if (op0 !== instr0[31:28]) begin
                errors++; $display("FAIL rand_opcode@%0d: got %h, want %h", i, op0, instr0[31:28]);
            end
            if (m0.imem_req === 1'b1) begin
                checks++;
                if (m0.imem_addr !== exp_req) begin
                    errors++; $display("FAIL rand_req@%0d: got addr %h, want %h", i, m0.imem_addr, exp_req);
                end
                exp_req = exp_req + 4;
            end
            prev_valid = valid0; prev_pc = pc0; prev_instr = instr0;
            stall = ($urandom % 3) == 0;
            prev_stall = stall;
        end
        stall = 1'b0;
        checks++;
        if (deliveries < 40) begin
            errors++; $display("FAIL rand_progress: got %0d deliveries, want >= 40", deliveries);
        end
    endtask

    task automatic test_wrap_async;
        logic [31:0] exp_list [3];
        int          nreq;
        exp_list[0] = 32'hFFFF_FFF8;
        exp_list[1] = 32'hFFFF_FFFC;
        exp_list[2] = 32'h0000_0000;
        nreq = 0;
        do_reset;
        for (int i = 0; i < 20 && nreq < 3; i++) begin
            tick;
            if (m1.imem_req === 1'b1) begin
                checks++;
                if (m1.imem_addr !== exp_list[nreq]) begin
                    errors++; $display("FAIL wrap_req%0d: got addr %h, want %h", nreq, m1.imem_addr, exp_list[nreq]);
                end
                nreq++;
            end
        end
        checks++;
        if (nreq != 3 || valid1 !== 1'b1 || pc1 !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_done: got %0d reqs valid %b pc %h, want 3/1/fffffffc", nreq, valid1, pc1);
        end
        // Async reset in WAIT with live IF/ID contents.
        do_reset;
        tick;
        tick;
        tick;
        stall1 = 1'b1;
        tick;
        checks++;
        if (valid1 !== 1'b1 || pc1 !== 32'hFFFF_FFF8 || m1.imem_addr !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL async_pre: got valid %b pc %h addr %h, want 1/fffffff8/fffffffc", valid1, pc1, m1.imem_addr);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({m1.imem_req, m1.imem_addr, instr1, pc1, valid1, op1} !== 102'h0) begin
            errors++; $display("FAIL async_reset: got req %b addr %h instr %h pc %h valid %b op %h, want all 0", m1.imem_req, m1.imem_addr, instr1, pc1, valid1, op1);
        end
        tick;
        stall1 = 1'b0;
        rst = 1'b0;
        tick;
        checks++;
        if (m1.imem_req !== 1'b1 || m1.imem_addr !== 32'hFFFF_FFF8) begin
            errors++; $display("FAIL async_restart: got req %b addr %h, want 1/fffffff8", m1.imem_req, m1.imem_addr);
        end
    endtask

    initial begin
        salt = 28'($urandom);
        test_reset;
        test_sequential;
        test_stall_hold;
        test_branch_drain;
        test_branch_conditions;
        test_squash_stall;
        test_random;
        test_wrap_async;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register feeding the opcode decoder.
- Holds the PC and issues one-outstanding-request reads to instruction memory.
- Captures returned words into IF/ID and presents the top 4 bits as the opcode.
- Resolves taken branches from the 2-bit branch-select code plus ALU flags; redirects the PC and squashes wrong-path instructions to NOP (all-zero).

Parameters:
PC_WIDTH, 32, width of PC and memory address
INSTR_WIDTH, 32, instruction word width; opcode is bits [INSTR_WIDTH-1:INSTR_WIDTH-4]
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
stall  in  1  decode/execute cannot accept a new IF/ID entry this cycle
branch_select  in  2  00 none, 01 always, 10 if zero flag, 11 if negative flag
flag_zero  in  1  ALU zero flag
flag_neg  in  1  ALU negative flag
branch_target  in  PC_WIDTH  redirect address
imem_req  out  1  read request; one-cycle pulse, always accepted
imem_addr  out  PC_WIDTH  read address, valid while imem_req=1
imem_ready  in  1  read data valid; at least 1 cycle after imem_req
imem_rdata  in  INSTR_WIDTH  returned instruction word
if_id_instr  out  INSTR_WIDTH  registered instruction, 0 when bubble
if_id_pc  out  PC_WIDTH  PC of if_id_instr
if_id_valid  out  1  IF/ID holds a real instruction
opcode  out  4  if_id_instr top 4 bits, to decoder

Behaviour:
- Reset (asynchronous, any state):
  - pc=RESET_PC, state=IDLE.
  - imem_req=0, imem_addr=0.
  - if_id_instr=0, if_id_pc=0, if_id_valid=0; hold buffer empty.
- taken = (branch_select==01) | (branch_select==10 & flag_zero) | (branch_select==11 & flag_neg). Combinational, acted on in the same edge.
- PC increments by 4, modulo 2^PC_WIDTH. Wrap from all-ones-minus-3 to 0 is legal and silent.
- IF/ID update rule, applied each edge unless a redirect occurs:
  - stall=1 and if_id_valid=1: hold.
  - Otherwise IF/ID loads the new word if one is delivered this cycle.
  - Else it becomes a bubble: instr=0, valid=0.
- FSM states: IDLE, REQ, WAIT, HOLD, DRAIN.
  - IDLE: one cycle after reset release; -> REQ.
  - REQ: imem_req=1, imem_addr=pc; -> WAIT.
  - WAIT: with imem_ready=1:
    - If IF/ID can accept (stall=0 or if_id_valid=0): deliver word with if_id_pc=pc, pc+=4, -> REQ.
    - Else: capture word and pc into the hold buffer, -> HOLD.
    - imem_ready=0: stay.
  - HOLD: when IF/ID can accept, deliver the hold buffer, pc+=4, -> REQ.
  - DRAIN: wait for imem_ready, discard data, -> REQ. No delivery.
- Redirect (taken=1) has priority over stall and delivery:
  - pc<=branch_target.
  - IF/ID forced to bubble (instr 0, valid 0) even if stall=1.
  - Hold buffer cleared.
  - From REQ, or WAIT with imem_ready=0: -> DRAIN.
  - From WAIT with imem_ready=1: data discarded, -> REQ.
  - From IDLE/HOLD/DRAIN: -> REQ. DRAIN with imem_ready=1 the same cycle -> REQ.
- Fetch latency: a request issued at edge N with imem_ready at N+k gives if_id_valid=1 after edge N+k.
- Throughput is one instruction every 2 cycles at best.
- Never more than one outstanding request. imem_req is never asserted in WAIT/HOLD/DRAIN.
- Squashed instructions read as opcode 0000, which the decoder treats as NOP.
- Output rules:
  - opcode = if_id_instr[INSTR_WIDTH-1:INSTR_WIDTH-4], purely combinational from the register.
  - if_id_pc is don't-care while valid=0, but is cleared on reset.

Test Plan:
- Reset then sequential fetch, imem_ready 1 cycle after each req, words 0x8xxxxxxx, 0x9xxxxxxx -> imem_addr 0,4,8 on successive req pulses. if_id_pc 0 then 4. opcode 1000 then 1001.
- Stall held 3 cycles while IF/ID valid with word at pc=8 returning -> state HOLD, IF/ID unchanged. After stall drop, if_id_pc=8 next edge, then req at addr 12.
- branch_select=10, flag_zero=1, target 0x40, during WAIT with no ready -> IF/ID bubble (opcode 0000, valid 0). Returning word discarded in DRAIN. Next req addr 0x40.
- branch_select=10, flag_zero=0 and branch_select=11, flag_neg=0 -> no redirect, sequential addresses continue. branch_select=11, flag_neg=1 -> redirect.
- Redirect with stall=1 and IF/ID valid -> IF/ID squashed regardless of stall. Hold buffer dropped.
- RESET_PC=0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0. rst asserted mid-WAIT -> outputs zero immediately (asynchronous). After release, first req at RESET_PC.
